// File: rtl/obs_pkg.sv
// Shared types and constants for the even/odd split GF(2) multiply sequencer.
// OBS_SEQ_KARATSUBA_EN selects the 3-sub-product Karatsuba schedule instead of the 4-product one.
package obs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } seq_state_t;

  typedef logic [1:0] sub_idx_t;

  localparam int K_SCHOOLBOOK = 4;
  localparam int K_KARATSUBA  = 3;

`ifdef OBS_SEQ_KARATSUBA_EN
  localparam int K_ISSUED = K_KARATSUBA;
`else
  localparam int K_ISSUED = K_SCHOOLBOOK;
`endif

endpackage

// File: rtl/obs_l1_sequencer_if.sv
// Handshake bundle between the sequencer, its operand source/product sink and the shared H-bit multiplier.
// slave is the sequencer's view, master is the environment's view.
interface obs_l1_sequencer_if #(
  parameter int N = 34
);
  localparam int H = N / 2;

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           sub_valid;
  logic           sub_ready;
  logic [H-1:0]   sub_a;
  logic [H-1:0]   sub_b;
  logic           sub_rsp_valid;
  logic [2*H-2:0] sub_rsp_data;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-2:0] out_prod;
  logic           err;

  modport slave (
    input  in_valid, in_a, in_b, sub_ready, sub_rsp_valid, sub_rsp_data, out_ready,
    output in_ready, sub_valid, sub_a, sub_b, out_valid, out_prod, err
  );

  modport master (
    output in_valid, in_a, in_b, sub_ready, sub_rsp_valid, sub_rsp_data, out_ready,
    input  in_ready, sub_valid, sub_a, sub_b, out_valid, out_prod, err
  );

endinterface

// File: rtl/obs_l1_sequencer_overlap.sv
// Combinational merge of the four even/odd sub-products into the full carry-less product.
// Even result bits take P1[i]^P4[i-1], odd bits take P2[i]^P3[i]; missing terms are zero.
module overlap_module_33bit #(
  parameter int H = 17
) (
  input  logic [2*H-2:0] p1,
  input  logic [2*H-2:0] p2,
  input  logic [2*H-2:0] p3,
  input  logic [2*H-2:0] p4,
  output logic [4*H-2:0] prod
);

  always_comb begin
    prod = '0;
    for (int i = 0; i < 2*H-1; i++) begin
      prod[2*i]   = prod[2*i] ^ p1[i];
      prod[2*i+1] = p2[i] ^ p3[i];
      prod[2*i+2] = prod[2*i+2] ^ p4[i];
    end
  end

endmodule

// File: rtl/obs_l1_sequencer.sv
// Sequences an N-bit carry-less multiply as H-bit sub-multiplies on a shared multiplier, then merges.
// OBS_SEQ_KARATSUBA_EN: issue 3 sub-products (Ae*Be, Ao*Bo, (Ae^Ao)*(Be^Bo)) instead of 4.
module obs_l1_sequencer
  import obs_pkg::*;
#(
  parameter int N = 34
) (
  input logic                clk,
  input logic                rst_n,
  obs_l1_sequencer_if.slave  bus
);

  localparam int H  = N / 2;
  localparam int PW = 2 * H - 1;
  localparam int OW = 2 * N - 1;
  localparam sub_idx_t K_LAST = sub_idx_t'(K_ISSUED - 1);

  seq_state_t    state;
  sub_idx_t      k;
  sub_idx_t      k_next;
  logic [H-1:0]  ae, ao, be, bo;
  logic [H-1:0]  in_ae, in_ao, in_be, in_bo;
  logic [H-1:0]  op_ae, op_ao, op_be, op_bo;
  logic [H-1:0]  sel_a, sel_b;
  logic [PW-1:0] p1, p2, p3, p4;
  logic [PW-1:0] p1_nxt, p2_nxt, p3_nxt, p4_nxt;
  logic [OW-1:0] merged;
  logic          in_ready_q, sub_valid_q, out_valid_q, err_q;
  logic [H-1:0]  sub_a_q, sub_b_q;
  logic [OW-1:0] out_prod_q;

  always_comb begin
    in_ae = '0;
    in_ao = '0;
    in_be = '0;
    in_bo = '0;
    for (int i = 0; i < H; i++) begin
      in_ae[i] = bus.in_a[2*i];
      in_ao[i] = bus.in_a[2*i+1];
      in_be[i] = bus.in_b[2*i];
      in_bo[i] = bus.in_b[2*i+1];
    end
  end

  // The first request is built straight from the incoming pair so it can be issued on the accept edge.
  always_comb begin
    k_next = (state == IDLE) ? '0 : sub_idx_t'(k + 2'd1);
    op_ae  = (state == IDLE) ? in_ae : ae;
    op_ao  = (state == IDLE) ? in_ao : ao;
    op_be  = (state == IDLE) ? in_be : be;
    op_bo  = (state == IDLE) ? in_bo : bo;
    sel_a  = '0;
    sel_b  = '0;
`ifdef OBS_SEQ_KARATSUBA_EN
    case (k_next)
      2'd0: begin sel_a = op_ae;         sel_b = op_be;         end
      2'd1: begin sel_a = op_ao;         sel_b = op_bo;         end
      2'd2: begin sel_a = op_ae ^ op_ao; sel_b = op_be ^ op_bo; end
      default: begin end
    endcase
`else
    case (k_next)
      2'd0: begin sel_a = op_ae; sel_b = op_be; end
      2'd1: begin sel_a = op_ae; sel_b = op_bo; end
      2'd2: begin sel_a = op_ao; sel_b = op_be; end
      2'd3: begin sel_a = op_ao; sel_b = op_bo; end
    endcase
`endif
  end

  // Next-state view of the P registers so the merge sees the final capture on the DONE-entry edge.
  always_comb begin
    p1_nxt = p1;
    p2_nxt = p2;
    p3_nxt = p3;
    p4_nxt = p4;
    if (state == WAIT && bus.sub_rsp_valid) begin
`ifdef OBS_SEQ_KARATSUBA_EN
      case (k)
        2'd0: p1_nxt = bus.sub_rsp_data;
        2'd1: p4_nxt = bus.sub_rsp_data;
        2'd2: p2_nxt = bus.sub_rsp_data ^ p1 ^ p4;
        default: begin end
      endcase
`else
      case (k)
        2'd0: p1_nxt = bus.sub_rsp_data;
        2'd1: p2_nxt = bus.sub_rsp_data;
        2'd2: p3_nxt = bus.sub_rsp_data;
        2'd3: p4_nxt = bus.sub_rsp_data;
      endcase
`endif
    end
  end

  overlap_module_33bit #(
    .H (H)
  ) u_merge (
    .p1   (p1_nxt),
    .p2   (p2_nxt),
    .p3   (p3_nxt),
    .p4   (p4_nxt),
    .prod (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      ae          <= '0;
      ao          <= '0;
      be          <= '0;
      bo          <= '0;
      p1          <= '0;
      p2          <= '0;
      p3          <= '0;
      p4          <= '0;
      in_ready_q  <= 1'b1;
      sub_valid_q <= 1'b0;
      sub_a_q     <= '0;
      sub_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (bus.sub_rsp_valid && state != WAIT) begin
        err_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ae          <= in_ae;
            ao          <= in_ao;
            be          <= in_be;
            bo          <= in_bo;
            k           <= '0;
            p1          <= '0;
            p2          <= '0;
            p3          <= '0;
            p4          <= '0;
            sub_a_q     <= sel_a;
            sub_b_q     <= sel_b;
            sub_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.sub_ready) begin
            sub_valid_q <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.sub_rsp_valid) begin
            p1 <= p1_nxt;
            p2 <= p2_nxt;
            p3 <= p3_nxt;
            p4 <= p4_nxt;
            if (k == K_LAST) begin
              out_prod_q  <= merged;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              k           <= k_next;
              sub_a_q     <= sel_a;
              sub_b_q     <= sel_b;
              sub_valid_q <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sub_valid = sub_valid_q;
  assign bus.sub_a     = sub_a_q;
  assign bus.sub_b     = sub_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = out_prod_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_obs_l1_sequencer.sv
// Directed bench for obs_l1_sequencer with a one-cycle-latency multiplier model on the sub port.
// Build with OBS_SEQ_KARATSUBA_EN defined to exercise the 3-sub-product schedule.
module tb_obs_l1_sequencer;

  localparam int N  = 34;
  localparam int H  = N / 2;
  localparam int OW = 2 * N - 1;
`ifdef OBS_SEQ_KARATSUBA_EN
  localparam int K_EXP = 3;
`else
  localparam int K_EXP = 4;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   hs_count;
  logic inject;
  logic rsp_pend;
  logic [2*H-2:0] pend_data;

  obs_l1_sequencer_if #(.N(N)) bus ();

  obs_l1_sequencer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*H-2:0] clmul_h(input logic [H-1:0] x, input logic [H-1:0] y);
    logic [2*H-2:0] r;
    r = '0;
    for (int i = 0; i < H; i++) begin
      if (y[i]) r = r ^ ((2*H-1)'(x) << i);
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] clmul_n(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (y[i]) r = r ^ (OW'(x) << i);
    end
    return r;
  endfunction

  // Multiplier model: a request accepted on one edge is answered for exactly the following cycle.
  initial begin
    rsp_pend              = 1'b0;
    pend_data             = '0;
    bus.sub_rsp_valid     = 1'b0;
    bus.sub_rsp_data      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rsp_pend          = 1'b0;
        bus.sub_rsp_valid = 1'b0;
        bus.sub_rsp_data  = '0;
      end else begin
        bus.sub_rsp_valid = rsp_pend | inject;
        bus.sub_rsp_data  = rsp_pend ? pend_data : '0;
        rsp_pend          = bus.sub_valid && bus.sub_ready;
        if (rsp_pend) begin
          pend_data = clmul_h(bus.sub_a, bus.sub_b);
          hs_count++;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitDone(output int cyc);
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("out_valid_rise", 128'(bus.out_valid), 128'(1));
  endtask

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               output logic [OW-1:0] prod, output int cyc);
    hs_count     = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    waitDone(cyc);
    prod = bus.out_prod;
  endtask

  task automatic popOutput();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_in_ready"},  128'(bus.in_ready),  128'(1));
    checkOutput({tag, "_sub_valid"}, 128'(bus.sub_valid), 128'(0));
    checkOutput({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
  endtask

  initial begin
    logic [OW-1:0] prod;
    logic [OW-1:0] held;
    logic [OW-1:0] exp_ones;
    int            cyc;

    checks        = 0;
    failures      = 0;
    hs_count      = 0;
    inject        = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.sub_ready = 1'b1;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    checkOutput("reset_err",  128'(bus.err),      128'(0));
    checkOutput("reset_prod", 128'(bus.out_prod), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] unit operands");
    applyStimulus(34'h1, 34'h1, prod, cyc);
    checkOutput("one_prod", 128'(prod), 128'(1));
    checkOutput("one_handshakes", 128'(hs_count), 128'(K_EXP));
    popOutput();
    checkIdle("one_pop");

    applyStimulus(34'h2, 34'h2, prod, cyc);
    checkOutput("x_sq", 128'(prod), 128'(67'h4));
    popOutput();

    applyStimulus(34'h3, 34'h3, prod, cyc);
    checkOutput("x1_sq", 128'(prod), 128'(67'h5));
    popOutput();

    applyStimulus(34'h2_0000_0000, 34'h2_0000_0000, prod, cyc);
    checkOutput("top_bit_sq", 128'(prod), 128'(67'd1) << 66);
    popOutput();

    applyStimulus(34'h2_A5C3_0F96, 34'h1_3579_BDF1, prod, cyc);
    checkOutput("mixed", 128'(prod), 128'(clmul_n(34'h2_A5C3_0F96, 34'h1_3579_BDF1)));
    popOutput();

    $display("[TB] all-ones operands and latency");
    exp_ones = '0;
    for (int i = 0; i < OW; i += 2) exp_ones[i] = 1'b1;
    applyStimulus({N{1'b1}}, {N{1'b1}}, prod, cyc);
    checkOutput("ones_prod", 128'(prod), 128'(exp_ones));
    checkOutput("ones_latency", 128'(cyc), 128'(2*K_EXP+1));
    checkOutput("ones_err", 128'(bus.err), 128'(0));

    $display("[TB] output backpressure");
    held         = bus.out_prod;
    bus.in_a     = 34'h2;
    bus.in_b     = 34'h2;
    bus.in_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      checkOutput("bp_out_valid", 128'(bus.out_valid), 128'(1));
      checkOutput("bp_prod_stable", 128'(bus.out_prod), 128'(held));
      checkOutput("bp_in_ready", 128'(bus.in_ready), 128'(0));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkIdle("bp_pop");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("bp_accept_in_ready", 128'(bus.in_ready), 128'(0));
    checkOutput("bp_accept_sub_valid", 128'(bus.sub_valid), 128'(1));
    waitDone(cyc);
    checkOutput("bp_next_prod", 128'(bus.out_prod), 128'(67'h4));
    popOutput();

    $display("[TB] reset during third sub-product wait");
    bus.in_a     = {N{1'b1}};
    bus.in_b     = 34'h1_2345_6789;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mid_wait_sub_valid", 128'(bus.sub_valid), 128'(0));
    rst_n = 1'b0;
    #1;
    checkIdle("mid_reset");
    checkOutput("mid_reset_err",  128'(bus.err),      128'(0));
    checkOutput("mid_reset_prod", 128'(bus.out_prod), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(34'h5, 34'h3, prod, cyc);
    checkOutput("after_reset_prod", 128'(prod), 128'(67'hF));
    checkOutput("after_reset_err", 128'(bus.err), 128'(0));
    popOutput();

    $display("[TB] stray sub response in IDLE");
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    checkOutput("stray_err", 128'(bus.err), 128'(1));
    @(posedge clk);
    #1;
    checkIdle("stray_fsm");
    applyStimulus(34'h3, 34'h3, prod, cyc);
    checkOutput("stray_next_prod", 128'(prod), 128'(67'h5));
    checkOutput("stray_err_sticky", 128'(bus.err), 128'(1));
    popOutput();
    checkOutput("stray_err_after_pop", 128'(bus.err), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

endmodule
